hbridge_sequencer: RTL and testbench

- Parametrised start-up, gating and protection sequencer for N_LEG half-bridge legs, placed between the dead-time block and the MOSFET gate pins.
- Enable flow: bootstrap-charge phase (all low sides on), then tank pre-charge phase (fixed forced pattern), then passes the control-law gate commands through.
- Latches shoot-through and external faults until an explicit clear.
- Replaces the ad-hoc start-up counters and gate equations with one generic, registered block.

---
 rtl/hbridge_sequencer.sv | 131 +++++++++++++
 tb/tb_hbridge_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_sequencer.sv
// hbridge_sequencer
// Start-up, gating and protection sequencer for N_LEG half-bridge legs.
// It sits between the dead-time block and the MOSFET gate pins.
// On enable it runs a bootstrap-charge phase with all low sides on, then an
// optional tank pre-charge phase with a fixed gate word, then passes the
// control-law gate commands through.
// Shoot-through and external faults latch until an explicit clear.
// o_gate is always registered from the state that is about to be entered, so
// an offending input word can never reach the gate pins.

module hbridge_sequencer #(
    parameter int                 N_LEG             = 2,
    parameter int                 CNT_W             = 16,
    parameter int                 BOOT_CYCLES       = 1000,
    parameter int                 PRECHARGE_CYCLES  = 1600,
    parameter logic [2*N_LEG-1:0] PRECHARGE_PATTERN = 4'b1001
) (
    input  logic                 i_clock,
    input  logic                 i_RESET,
    input  logic                 i_enable,
    input  logic [2*N_LEG-1:0]   i_mosfet,
    input  logic                 i_ext_fault,
    input  logic                 i_fault_clear,
    output logic [2*N_LEG-1:0]   o_gate,
    output logic [2:0]           o_state,
    output logic                 o_running,
    output logic                 o_fault,
    output logic [1:0]           o_fault_code
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_BOOT      = 3'd1;
    localparam logic [2:0] ST_PRECHARGE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    // Terminal counter values. A zero-length pre-charge never uses its
    // terminal value, so it is clamped to keep the constant in range.
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  =
        CNT_W'((PRECHARGE_CYCLES > 0) ? (PRECHARGE_CYCLES - 1) : 0);
    localparam logic [2:0] BOOT_EXIT =
        (PRECHARGE_CYCLES == 0) ? ST_RUN : ST_PRECHARGE;

    // Low sides occupy the upper half of the gate word.
    localparam logic [2*N_LEG-1:0] BOOT_PATTERN = {{N_LEG{1'b1}}, {N_LEG{1'b0}}};

    logic [2:0]         state;
    logic [2:0]         base_next;
    logic [2:0]         next_state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   next_count;
    logic [2*N_LEG-1:0] gate_next;
    logic               shoot_through;
    logic               st_fault;
    logic [1:0]         new_code;

    // Ordinary sequencing, ignoring the two fault causes which override it
    always_comb begin
        base_next = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) base_next = ST_BOOT;
            end
            ST_BOOT: begin
                if (!i_enable)               base_next = ST_IDLE;
                else if (count == BOOT_LAST) base_next = BOOT_EXIT;
            end
            ST_PRECHARGE: begin
                if (!i_enable)              base_next = ST_IDLE;
                else if (count == PRE_LAST) base_next = ST_RUN;
            end
            ST_RUN: begin
                if (!i_enable) base_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (i_fault_clear && !i_enable && !i_ext_fault) base_next = ST_IDLE;
            end
            default: base_next = ST_IDLE;
        endcase
    end

    // Fault overrides: shoot-through only matters when the input word is,
    // or is about to be, passed through to the gates
    always_comb begin
        shoot_through = |(i_mosfet[N_LEG-1:0] & i_mosfet[2*N_LEG-1:N_LEG]);
        st_fault      = shoot_through && ((state == ST_RUN) || (base_next == ST_RUN));
        new_code      = {i_ext_fault, st_fault};
        next_state    = (i_ext_fault || st_fault) ? ST_FAULT : base_next;
    end

    // Phase counter advances only while staying in BOOT or PRECHARGE
    always_comb begin
        next_count = '0;
        if (((state == ST_BOOT) || (state == ST_PRECHARGE)) && (next_state == state))
            next_count = count + CNT_W'(1);
    end

    // Gate word selected by the state being entered on this edge
    always_comb begin
        gate_next = '0;
        case (next_state)
            ST_BOOT:      gate_next = BOOT_PATTERN;
            ST_PRECHARGE: gate_next = PRECHARGE_PATTERN;
            ST_RUN:       gate_next = i_mosfet;
            default:      gate_next = '0;
        endcase
    end

    // State, counter and all registered outputs
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            state        <= ST_IDLE;
            count        <= '0;
            o_gate       <= '0;
            o_running    <= 1'b0;
            o_fault      <= 1'b0;
            o_fault_code <= 2'b00;
        end else begin
            state        <= next_state;
            count        <= next_count;
            o_gate       <= gate_next;
            o_running    <= (next_state == ST_RUN);
            o_fault      <= (next_state == ST_FAULT);
            o_fault_code <= (next_state == ST_FAULT) ? (o_fault_code | new_code) : 2'b00;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// tb_hbridge_sequencer
// Exercises the default 2-leg configuration and a 3-leg configuration with
// no pre-charge phase. Expected observations are queued as stimulus is
// driven and compared against what the DUT shows one edge later.

module tb_hbridge_sequencer;

    typedef struct packed {
        logic [5:0] gate;
        logic [2:0] state;
        logic [1:0] code;
        logic       running;
        logic       fault;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       enable = 1'b0;
    logic [3:0] mosfet = '0;
    logic       ext_fault = 1'b0;
    logic       fault_clear = 1'b0;
    logic [3:0] gate;
    logic [2:0] state;
    logic       running;
    logic       fault;
    logic [1:0] code;

    logic       enable2 = 1'b0;
    logic [5:0] mosfet2 = '0;
    logic       ext2 = 1'b0;
    logic       clr2 = 1'b0;
    logic [5:0] gate2;
    logic [2:0] state2;
    logic       running2;
    logic       fault2;
    logic [1:0] code2;

    int   checks = 0;
    int   passed = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    hbridge_sequencer dut (
        .i_clock       (clock),
        .i_RESET       (reset),
        .i_enable      (enable),
        .i_mosfet      (mosfet),
        .i_ext_fault   (ext_fault),
        .i_fault_clear (fault_clear),
        .o_gate        (gate),
        .o_state       (state),
        .o_running     (running),
        .o_fault       (fault),
        .o_fault_code  (code)
    );

    hbridge_sequencer #(
        .N_LEG             (3),
        .CNT_W             (16),
        .BOOT_CYCLES       (4),
        .PRECHARGE_CYCLES  (0),
        .PRECHARGE_PATTERN (6'b000000)
    ) dut2 (
        .i_clock       (clock),
        .i_RESET       (reset),
        .i_enable      (enable2),
        .i_mosfet      (mosfet2),
        .i_ext_fault   (ext2),
        .i_fault_clear (clr2),
        .o_gate        (gate2),
        .o_state       (state2),
        .o_running     (running2),
        .o_fault       (fault2),
        .o_fault_code  (code2)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t mk(input logic [5:0] g, input logic [2:0] s, input logic [1:0] c);
        obs_t o;
        o.gate    = g;
        o.state   = s;
        o.code    = c;
        o.running = (s == 3'd3);
        o.fault   = (s == 3'd4);
        return o;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) o = {gate2, state2, code2, running2, fault2};
        else     o = {2'b00, gate, state, code, running, fault};
        return o;
    endfunction

    // One clock of stimulus on the chosen DUT; expectation queued now, observation after the edge
    task automatic cycle(input bit sel, input logic en, input logic [5:0] mos,
                         input logic ext, input logic clr, input obs_t e);
        if (!sel) begin
            enable      = en;
            mosfet      = mos[3:0];
            ext_fault   = ext;
            fault_clear = clr;
        end else begin
            enable2 = en;
            mosfet2 = mos;
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        obs_q.push_back(sample(sel));
    endtask

    task automatic test_reset();
        obs_t o;
        o = sample(0);
        checks++;
        if (o !== mk(6'd0, 3'd0, 2'd0))
            $display("[TB] FAIL reset_leg2: got gate=%b state=%0d code=%b run=%b flt=%b, want all zero",
                     o.gate, o.state, o.code, o.running, o.fault);
        else passed++;
        o = sample(1);
        checks++;
        if (o !== mk(6'd0, 3'd0, 2'd0))
            $display("[TB] FAIL reset_leg3: got gate=%b state=%0d code=%b run=%b flt=%b, want all zero",
                     o.gate, o.state, o.code, o.running, o.fault);
        else passed++;
    endtask

    task automatic test_defaults();
        logic [5:0] run_pats [4];
        run_pats = '{6'b000110, 6'b001001, 6'b000010, 6'b001000};
        for (int i = 0; i < 1000; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001100, 3'd1, 2'd0));
        for (int i = 0; i < 1600; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001001, 3'd2, 2'd0));
        for (int i = 0; i < 4; i++) cycle(0, 1, run_pats[i], 0, 0, mk(run_pats[i], 3'd3, 2'd0));
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e)
                $display("[TB] FAIL defaults: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o.gate, o.state, o.code, o.running, o.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    task automatic test_shoot_through();
        cycle(0, 1, 6'b000101, 0, 0, mk(6'd0, 3'd4, 2'b01));
        cycle(0, 1, 6'b000110, 0, 1, mk(6'd0, 3'd4, 2'b01));
        cycle(0, 1, 6'b000110, 1, 0, mk(6'd0, 3'd4, 2'b11));
        cycle(0, 0, 6'b000110, 1, 1, mk(6'd0, 3'd4, 2'b11));
        cycle(0, 0, 6'b000110, 0, 1, mk(6'd0, 3'd0, 2'b00));
        cycle(0, 0, 6'b000110, 0, 0, mk(6'd0, 3'd0, 2'b00));
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e)
                $display("[TB] FAIL shoot_through: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o.gate, o.state, o.code, o.running, o.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    task automatic test_ext_fault_boot();
        for (int i = 0; i < 501; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001100, 3'd1, 2'd0));
        cycle(0, 1, 6'b000110, 1, 0, mk(6'd0, 3'd4, 2'b10));
        cycle(0, 1, 6'b000110, 0, 0, mk(6'd0, 3'd4, 2'b10));
        cycle(0, 0, 6'b000110, 0, 1, mk(6'd0, 3'd0, 2'b00));
        for (int i = 0; i < 1000; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001100, 3'd1, 2'd0));
        cycle(0, 1, 6'b000110, 0, 0, mk(6'b001001, 3'd2, 2'd0));
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e)
                $display("[TB] FAIL ext_fault_boot: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o.gate, o.state, o.code, o.running, o.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    task automatic test_precharge_gap();
        for (int i = 0; i < 800; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001001, 3'd2, 2'd0));
        for (int i = 0; i < 3; i++) cycle(0, 0, 6'b000110, 0, 0, mk(6'd0, 3'd0, 2'd0));
        for (int i = 0; i < 1000; i++) cycle(0, 1, 6'b000110, 0, 0, mk(6'b001100, 3'd1, 2'd0));
        cycle(0, 1, 6'b000110, 0, 0, mk(6'b001001, 3'd2, 2'd0));
        cycle(0, 0, 6'b000110, 0, 0, mk(6'd0, 3'd0, 2'd0));
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e)
                $display("[TB] FAIL precharge_gap: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o.gate, o.state, o.code, o.running, o.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    task automatic test_no_precharge();
        for (int i = 0; i < 4; i++) cycle(1, 1, 6'b000101, 0, 0, mk(6'b111000, 3'd1, 2'd0));
        cycle(1, 1, 6'b000101, 0, 0, mk(6'b000101, 3'd3, 2'd0));
        cycle(1, 1, 6'b100010, 0, 0, mk(6'b100010, 3'd3, 2'd0));
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e)
                $display("[TB] FAIL no_precharge: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o.gate, o.state, o.code, o.running, o.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        #2;
        reset = 1'b1;
        #1;
        o = sample(1);
        checks++;
        if (o !== mk(6'd0, 3'd0, 2'd0))
            $display("[TB] FAIL async_reset_leg3: got gate=%b state=%0d run=%b, want gate=0 state=0 run=0",
                     o.gate, o.state, o.running);
        else passed++;
        o = sample(0);
        checks++;
        if (o !== mk(6'd0, 3'd0, 2'd0))
            $display("[TB] FAIL async_reset_leg2: got gate=%b state=%0d run=%b, want gate=0 state=0 run=0",
                     o.gate, o.state, o.running);
        else passed++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 1, 6'b100010, 0, 0, mk(6'b111000, 3'd1, 2'd0));
        cycle(1, 1, 6'b100010, 0, 0, mk(6'b100010, 3'd3, 2'd0));
        cycle(1, 1, 6'b100100, 0, 0, mk(6'd0, 3'd4, 2'b01));
        while (exp_q.size() > 0) begin
            obs_t e, o2;
            e  = exp_q.pop_front();
            o2 = obs_q.pop_front();
            checks++;
            if (o2 !== e)
                $display("[TB] FAIL async_restart: got gate=%b state=%0d code=%b run=%b flt=%b, want gate=%b state=%0d code=%b run=%b flt=%b",
                         o2.gate, o2.state, o2.code, o2.running, o2.fault, e.gate, e.state, e.code, e.running, e.fault);
            else passed++;
        end
    endtask

    initial begin
        $display("[TB] hbridge_sequencer bench start");
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        test_defaults();
        test_shoot_through();
        test_ext_fault_boot();
        test_precharge_gap();
        test_no_precharge();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
